// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter with burst limit for a shared synchronous-read memory port
// Ports:
//   clk, rstb                    clock, synchronous active-low reset
//   req/we/addr/wdata 0,1        requester access inputs
//   gnt0, gnt1                   combinational grants (transfer when reqN & gntN)
//   rvalid0, rvalid1, rdata      read return, rdata shared and qualified by rvalidN
//   mem_addr, mem_wr_data,
//   mem_wr_ena, mem_rd_data      memory port
//   gnt_cnt0, gnt_cnt1           per-requester grant counters, built only with MEM_ARB_PERF_EN
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_wr_ena,
    input  logic [DW-1:0] mem_rd_data,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] MB = BW'(MAX_BURST);
    logic              owner, owner_nxt;
    logic [BW-1:0]     burst_cnt, burst_nxt;
    logic [RD_LAT-1:0] tag_vld, tag_id;
    logic              granted, winner, sel, win_we;
    always_ff @(posedge clk) begin
        if (!rstb) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
            tag_vld   <= '0;
            tag_id    <= '0;
        end else begin
            owner      <= owner_nxt;
            burst_cnt  <= burst_nxt;
            tag_vld[0] <= granted & ~win_we;
            tag_id[0]  <= winner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end
    // Under contention the owner keeps the port until it has used its burst allowance.
    always_comb begin
        granted   = rstb & (req0 | req1);
        winner    = (req0 & req1) ? ((burst_cnt < MB) ? owner : ~owner) : req1;
        win_we    = winner ? we1 : we0;
        owner_nxt = granted ? winner : owner;
        burst_nxt = !granted ? burst_cnt :
                    (winner != owner) ? BW'(1) :
                    (burst_cnt == MB) ? MB : burst_cnt + 1'b1;
    end
    // With no grant the memory port follows the owner; in reset it is parked on requester 0.
    always_comb begin
        sel         = rstb & (granted ? winner : owner);
        gnt0        = granted & ~winner;
        gnt1        = granted & winner;
        mem_addr    = sel ? addr1 : addr0;
        mem_wr_data = sel ? wdata1 : wdata0;
        mem_wr_ena  = granted & win_we;
        rvalid0     = rstb & tag_vld[RD_LAT-1] & ~tag_id[RD_LAT-1];
        rvalid1     = rstb & tag_vld[RD_LAT-1] & tag_id[RD_LAT-1];
        rdata       = mem_rd_data;
    end
`ifdef MEM_ARB_PERF_EN
    logic [15:0] cnt0, cnt1;
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 1'b1;
            if (gnt1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 1'b1;
        end
    end
    assign gnt_cnt0 = cnt0;
    assign gnt_cnt1 = cnt1;
`else
    assign gnt_cnt0 = 16'h0000;
    assign gnt_cnt1 = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (instance 0: RD_LAT=1/MAX_BURST=4, instance 1: RD_LAT=3/MAX_BURST=1)
module tb_mem_arbiter;
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          at;
    } exp_t;
    logic clk = 1'b0;
    logic [1:0] rstb, req0, req1, we0, we1, gnt0, gnt1, rvalid0, rvalid1, mem_wr_ena;
    logic [1:0][31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wr_data, rd_data;
    logic [1:0][15:0] gc0, gc1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    mem_arbiter #(.RD_LAT(1), .MAX_BURST(4)) dut0 (
        .clk(clk), .rstb(rstb[0]), .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]), .rdata(rdata[0]),
        .mem_addr(mem_addr[0]), .mem_wr_data(mem_wr_data[0]), .mem_wr_ena(mem_wr_ena[0]),
        .mem_rd_data(rd_data[0]), .gnt_cnt0(gc0[0]), .gnt_cnt1(gc1[0]));
    mem_arbiter #(.RD_LAT(3), .MAX_BURST(1)) dut1 (
        .clk(clk), .rstb(rstb[1]), .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]), .rdata(rdata[1]),
        .mem_addr(mem_addr[1]), .mem_wr_data(mem_wr_data[1]), .mem_wr_ena(mem_wr_ena[1]),
        .mem_rd_data(rd_data[1]), .gnt_cnt0(gc0[1]), .gnt_cnt1(gc1[1]));
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // Memory model: unwritten word at address a reads 0x1000_0000 + a/4; read data is delayed by LAT cycles.
    for (genvar g = 0; g < 2; g++) begin : m
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] wmem [256];
        logic [255:0] wv;
        logic [31:0] d [3];
        logic [7:0] a;
        exp_t q[$];
        exp_t e;
        assign a = mem_addr[g][9:2];
        assign rd_data[g] = d[LAT-1];
        always @(posedge clk) begin
            if (!rstb[g]) wv <= '0;
            else if (mem_wr_ena[g]) begin
                wmem[a] <= mem_wr_data[g];
                wv[a]   <= 1'b1;
            end
            d[0] <= wv[a] ? wmem[a] : 32'h1000_0000 + {24'h0, a};
            d[1] <= d[0];
            d[2] <= d[1];
        end
        always @(negedge clk) begin
            if (rvalid0[g] | rvalid1[g]) begin
                chk("rvalid_both", {63'b0, rvalid0[g] & rvalid1[g]}, 64'd0);
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rvalid_unexpected: inst %0d got rvalid0=%0b rvalid1=%0b expected none (cycle %0d)",
                             g, rvalid0[g], rvalid1[g], cyc);
                end else begin
                    e = q.pop_front();
                    chk("rvalid_id", {63'b0, rvalid1[g]}, {63'b0, e.id});
                    chk("rdata", {32'b0, rdata[g]}, {32'b0, e.data});
                    chk("rvalid_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end
    task automatic step(input int k, input logic r0, input logic w0, input logic [31:0] a0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic eg0, input logic eg1, input logic ewe, input logic [31:0] ed);
        exp_t e;
        req0[k] = r0; we0[k] = w0; addr0[k] = a0;
        req1[k] = r1; we1[k] = w1; addr1[k] = a1; wdata1[k] = d1;
        @(negedge clk);
        chk("gnt0", {63'b0, gnt0[k]}, {63'b0, eg0});
        chk("gnt1", {63'b0, gnt1[k]}, {63'b0, eg1});
        chk("mem_wr_ena", {63'b0, mem_wr_ena[k]}, {63'b0, ewe});
        if (eg0 | eg1) chk("mem_addr", {32'b0, mem_addr[k]}, {32'b0, eg1 ? a1 : a0});
        if ((eg0 && !w0) || (eg1 && !w1)) begin
            e.id = eg1;
            e.data = ed;
            e.at = cyc + ((k == 0) ? 1 : 3);
            if (k == 0) m[0].q.push_back(e);
            else m[1].q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) step(k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        logic [8:0] seq;
        logic g;
        #100000;
        $display("FAIL timeout: simulation reached time limit, expected completion");
        $fatal(1);
        seq = 0; g = 0;
    end
    initial begin
        logic [8:0] seq;
        logic g;
        rstb = 2'b00; req0 = '0; req1 = '0; we0 = '0; we1 = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 32'h44;
        req1[0] = 1'b1; addr1[0] = 32'h88;
        @(negedge clk);
        chk("rst_gnt0", {63'b0, gnt0[0]}, 64'd0);
        chk("rst_gnt1", {63'b0, gnt1[0]}, 64'd0);
        chk("rst_wr_ena", {63'b0, mem_wr_ena[0]}, 64'd0);
        chk("rst_rvalid", {62'b0, rvalid1[0], rvalid0[0]}, 64'd0);
        chk("rst_mem_addr", {32'b0, mem_addr[0]}, 64'h44);
        @(posedge clk);
        #1;
        req0 = '0; req1 = '0; we0 = '0;
        rstb = 2'b11;
        step(0, 1, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 32'h1000_0000);
        step(0, 1, 0, 32'h4, 0, 0, 0, 0, 1, 0, 0, 32'h1000_0001);
        step(0, 1, 0, 32'h8, 0, 0, 0, 0, 1, 0, 0, 32'h1000_0002);
        idle(0, 1);
        rstb[0] = 1'b0;
        @(posedge clk);
        #1;
        rstb[0] = 1'b1;
        seq = 9'b0_1111_0000;
        for (int i = 0; i < 9; i++) begin
            g = seq[i];
            step(0, 1, 0, 32'h10, 1, 0, 32'h20, 0, !g, g, 0, g ? 32'h1000_0008 : 32'h1000_0004);
        end
`ifdef MEM_ARB_PERF_EN
        chk("gnt_cnt0", {48'b0, gc0[0]}, 64'd5);
        chk("gnt_cnt1", {48'b0, gc1[0]}, 64'd4);
`else
        chk("gnt_cnt0_off", {48'b0, gc0[0]}, 64'd0);
        chk("gnt_cnt1_off", {48'b0, gc1[0]}, 64'd0);
`endif
        step(0, 0, 0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 1, 1, 0);
        step(0, 1, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0, 32'hDEAD_BEEF);
        idle(0, 3);
        step(1, 1, 0, 32'h0, 1, 0, 32'h4, 0, 1, 0, 0, 32'h1000_0000);
        step(1, 1, 0, 32'h8, 1, 0, 32'h4, 0, 0, 1, 0, 32'h1000_0001);
        step(1, 1, 0, 32'h8, 1, 0, 32'hC, 0, 1, 0, 0, 32'h1000_0002);
        step(1, 1, 0, 32'h10, 1, 0, 32'hC, 0, 0, 1, 0, 32'h1000_0003);
        step(1, 1, 0, 32'h10, 0, 0, 0, 0, 1, 0, 0, 32'h1000_0004);
        idle(1, 4);
        step(1, 0, 0, 0, 1, 0, 32'h20, 0, 0, 1, 0, 0);
        // this read is killed by the reset below, so it must never return
        void'(m[1].q.pop_back());
        rstb[1] = 1'b0;
        @(negedge clk);
        chk("midrst_gnt1", {63'b0, gnt1[1]}, 64'd0);
        chk("midrst_rvalid", {62'b0, rvalid1[1], rvalid0[1]}, 64'd0);
        @(posedge clk);
        #1;
        rstb[1] = 1'b1;
        step(1, 1, 0, 32'h24, 1, 0, 32'h28, 0, 1, 0, 0, 32'h1000_0009);
        step(1, 1, 0, 32'h2C, 1, 0, 32'h28, 0, 0, 1, 0, 32'h1000_000A);
        step(1, 1, 0, 32'h2C, 0, 0, 0, 0, 1, 0, 0, 32'h1000_000B);
        idle(1, 5);
        chk("queue_empty0", 64'(m[0].q.size()), 64'd0);
        chk("queue_empty1", 64'(m[1].q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
